// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the transmit frame arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_arb_pkg;

    localparam int LEN_W  = 11;
    localparam int MAXLEN = 1514;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // A frame of zero bytes or longer than the largest Ethernet frame is refused.
    function automatic logic len_legal(input logic [LEN_W-1:0] l);
        return (l != '0) && (int'(l) <= MAXLEN);
    endfunction

endpackage

// File: rtl/tx_frame_arb_if.sv
// Bundle between frame sources / tx engine and the transmit arbiter.
// Latency: n/a (wiring only).
// Backpressure: sources hold req level until granted; the engine answers with tx_done.
interface tx_frame_arb_if
    import tx_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int LEN_W = tx_arb_pkg::LEN_W
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rej;
    logic                  tx_start;
    logic [SW-1:0]         tx_sel;
    logic [LEN_W-1:0]      tx_len;
    logic                  tx_done;
    logic                  tx_abort;
    logic                  busy;
    logic [7:0]            err_cnt;

    // Arbiter side
    modport master (
        input  req, len, tx_done,
        output gnt, rej, tx_start, tx_sel, tx_len, tx_abort, busy, err_cnt
    );

    // Sources and tx engine side
    modport slave (
        output req, len, tx_done,
        input  gnt, rej, tx_start, tx_sel, tx_len, tx_abort, busy, err_cnt
    );

endinterface

// File: rtl/tx_frame_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; caller decides when to act on the pick.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          vld,
    output logic [PW-1:0] idx
);

    // Scan from farthest to nearest so the nearest hit to ptr is the last write.
    always_comb begin
        int j;
        j   = 0;
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                vld = 1'b1;
                idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/tx_frame_arb.sv
// Round-robin scheduler of frame sources onto the single RGMII transmit engine.
// Latency: req -> tx_start 1 cycle; IFG idle cycles after done/abort before next start.
// Backpressure: one grant at a time; requests wait while busy; hung frames abort after TIMEOUT.
module tx_frame_arb
    import tx_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int IFG     = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk125,
    input  logic           reset_n,
    tx_frame_arb_if.master bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(IFG) + 1;

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GMAX = GW'(IFG - 1);

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [TW-1:0]    timer;
    logic [GW-1:0]    gap_cnt;

    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  rej_q;
    logic             start_q;
    logic [PW-1:0]    sel_q;
    logic [LEN_W-1:0] len_q;
    logic             abort_q;
    logic             busy_q;
    logic [7:0]       err_q;

    logic             win_vld;
    logic [PW-1:0]    win_idx;
    logic [LEN_W-1:0] win_len;
    logic [NREQ-1:0]  win_oh;

    // Pointer just past a served or rejected source, so it goes to the back of the line.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] i);
        return (int'(i) >= NREQ - 1) ? '0 : i + PW'(1);
    endfunction

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .vld (win_vld),
        .idx (win_idx)
    );

    assign win_len = bus.len[int'(win_idx)*LEN_W +: LEN_W];
    assign win_oh  = NREQ'(1) << win_idx;

    // Arbiter FSM: pick in IDLE, watch the engine in BUSY, hold off in GAP.
    always_ff @(posedge clk125 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            timer   <= '0;
            gap_cnt <= '0;
            gnt_q   <= '0;
            rej_q   <= '0;
            start_q <= 1'b0;
            sel_q   <= '0;
            len_q   <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            start_q <= 1'b0;
            rej_q   <= '0;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        if (len_legal(win_len)) begin
                            gnt_q   <= win_oh;
                            sel_q   <= win_idx;
                            len_q   <= win_len;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            timer   <= '0;
                            state   <= BUSY;
                        end else begin
                            // Refuse the bad frame and move on so it cannot starve others.
                            rej_q <= win_oh;
                            ptr   <= ptr_next(win_idx);
                        end
                    end
                end
                BUSY: begin
                    // Done is checked first so it beats a same-cycle timeout.
                    if (bus.tx_done) begin
                        gnt_q   <= '0;
                        ptr     <= ptr_next(sel_q);
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (timer == TMAX) begin
                        abort_q <= 1'b1;
                        if (err_q != 8'hFF) begin
                            err_q <= err_q + 8'd1;
                        end
                        gnt_q   <= '0;
                        ptr     <= ptr_next(sel_q);
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GMAX) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rej      = rej_q;
    assign bus.tx_start = start_q;
    assign bus.tx_sel   = sel_q;
    assign bus.tx_len   = len_q;
    assign bus.tx_abort = abort_q;
    assign bus.busy     = busy_q;
    assign bus.err_cnt  = err_q;

endmodule

// File: tb/tb_tx_frame_arb.sv
// Directed bench for tx_frame_arb: grant order, gap timing, rejects, timeout, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_tx_frame_arb;

    logic clk125;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    tx_frame_arb_if #(.NREQ(3), .LEN_W(11)) bus ();
    tx_frame_arb_if #(.NREQ(3), .LEN_W(11)) bus_s ();

    tx_frame_arb #(.NREQ(3), .IFG(12), .TIMEOUT(4096)) dut (
        .clk125  (clk125),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Short timeout instance so hundreds of aborts fit in a small run.
    tx_frame_arb #(.NREQ(3), .IFG(12), .TIMEOUT(16)) dut_sat (
        .clk125  (clk125),
        .reset_n (reset_n),
        .bus     (bus_s)
    );

    initial clk125 = 1'b0;
    always #4 clk125 = ~clk125;

    task automatic tick();
        @(posedge clk125);
        @(negedge clk125);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i*11 +: 11] = 11'(v);
    endtask

    task automatic wait_start(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.tx_start !== 1'b1 && cyc < max);
    endtask

    task automatic finish_frame(input int edges);
        repeat (edges - 1) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        int cyc;
        int aborts;
        int n;
        logic [7:0] e254;
        int exp_ord [4] = '{0, 1, 2, 0};

        e254          = '0;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.len       = '0;
        bus.tx_done   = 1'b0;
        bus_s.req     = '0;
        bus_s.len     = '0;
        bus_s.tx_done = 1'b0;

        // Reset state
        @(negedge clk125);
        tick();
        check("rst_gnt", bus.gnt, 0);
        check("rst_rej", bus.rej, 0);
        check("rst_start", bus.tx_start, 0);
        check("rst_abort", bus.tx_abort, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err_cnt, 0);
        check("rst_len", bus.tx_len, 0);
        reset_n = 1'b1;
        tick();

        // 1: single source, 64 bytes, done 70 cycles after start
        set_len(0, 64);
        bus.req = 3'b001;
        tick();
        check("t1_start", bus.tx_start, 1);
        check("t1_gnt", bus.gnt, 3'b001);
        check("t1_sel", bus.tx_sel, 0);
        check("t1_len", bus.tx_len, 64);
        check("t1_busy", bus.busy, 1);
        bus.req = 3'b000;
        tick();
        check("t1_start_pulse", bus.tx_start, 0);
        check("t1_gnt_held", bus.gnt, 3'b001);
        repeat (68) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("t1_gnt_clr", bus.gnt, 0);
        check("t1_busy_gap", bus.busy, 1);
        repeat (11) tick();
        check("t1_busy_11", bus.busy, 1);
        tick();
        check("t1_busy_12", bus.busy, 0);

        // 2: all three requesting, 20-cycle frames, order 0,1,2,0 from ptr 0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        set_len(0, 100);
        set_len(1, 100);
        set_len(2, 100);
        bus.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_start(40, cyc);
            check("t2_start", bus.tx_start, 1);
            check("t2_sel", bus.tx_sel, exp_ord[k]);
            check("t2_gnt", bus.gnt, 3'b001 << exp_ord[k]);
            check("t2_len", bus.tx_len, 100);
            if (k > 0) check("t2_spacing", cyc, 13);
            if (k == 3) bus.req = 3'b000;
            repeat (19) tick();
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
        end
        repeat (12) tick();
        check("t2_idle", bus.busy, 0);

        // 3: illegal lengths rejected, boundary length granted
        set_len(1, 0);
        bus.req = 3'b010;
        tick();
        check("t3_rej0", bus.rej, 3'b010);
        check("t3_nostart0", bus.tx_start, 0);
        check("t3_nognt0", bus.gnt, 0);
        bus.req = 3'b000;
        tick();
        check("t3_rej_pulse", bus.rej, 0);
        set_len(1, 1515);
        bus.req = 3'b010;
        tick();
        check("t3_rej1515", bus.rej, 3'b010);
        check("t3_nostart1515", bus.tx_start, 0);
        bus.req = 3'b000;
        tick();
        set_len(1, 1514);
        bus.req = 3'b010;
        tick();
        check("t3_start1514", bus.tx_start, 1);
        check("t3_sel1514", bus.tx_sel, 1);
        check("t3_len1514", bus.tx_len, 1514);
        check("t3_norej1514", bus.rej, 0);
        bus.req = 3'b000;
        finish_frame(10);

        // 4: source 2 hangs, abort on the 4096th BUSY cycle, next grant to 0
        set_len(2, 200);
        bus.req = 3'b100;
        tick();
        check("t4_start", bus.tx_start, 1);
        check("t4_sel", bus.tx_sel, 2);
        bus.req = 3'b000;
        repeat (4095) tick();
        check("t4_no_abort_early", bus.tx_abort, 0);
        check("t4_gnt_held", bus.gnt, 3'b100);
        tick();
        check("t4_abort", bus.tx_abort, 1);
        check("t4_err", bus.err_cnt, 1);
        check("t4_gnt_clr", bus.gnt, 0);
        check("t4_busy", bus.busy, 1);
        bus.req = 3'b101;
        tick();
        check("t4_abort_pulse", bus.tx_abort, 0);
        wait_start(20, cyc);
        check("t4_restart", bus.tx_start, 1);
        check("t4_gap", cyc, 12);
        check("t4_next_sel", bus.tx_sel, 0);
        check("t4_next_len", bus.tx_len, 100);
        bus.req = 3'b000;
        finish_frame(10);

        // 5: done in the final BUSY cycle beats the timeout
        set_len(1, 50);
        bus.req = 3'b010;
        tick();
        check("t5_start", bus.tx_start, 1);
        check("t5_sel", bus.tx_sel, 1);
        bus.req = 3'b000;
        repeat (4095) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("t5_no_abort", bus.tx_abort, 0);
        check("t5_err_same", bus.err_cnt, 1);
        check("t5_gnt_clr", bus.gnt, 0);
        tick();
        check("t5_no_abort_late", bus.tx_abort, 0);
        repeat (11) tick();
        check("t5_idle", bus.busy, 0);

        // 5b: 300 forced aborts saturate the error counter
        bus_s.len[0 +: 11] = 11'd64;
        bus_s.req = 3'b001;
        aborts = 0;
        n = 0;
        while (aborts < 300 && n < 12000) begin
            tick();
            n++;
            if (bus_s.tx_abort === 1'b1) begin
                aborts++;
                if (aborts == 254) e254 = bus_s.err_cnt;
            end
        end
        bus_s.req = 3'b000;
        check("t5_abort_count", aborts, 300);
        check("t5_err_254", e254, 254);
        check("t5_err_sat", bus_s.err_cnt, 255);

        // 6: reset in the middle of a frame, then fresh scan from ptr 0
        set_len(0, 64);
        bus.req = 3'b001;
        tick();
        check("t6_start", bus.tx_start, 1);
        bus.req = 3'b000;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("t6_gnt", bus.gnt, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_abort", bus.tx_abort, 0);
        check("t6_err", bus.err_cnt, 0);
        tick();
        check("t6_abort_hold", bus.tx_abort, 0);
        reset_n = 1'b1;
        tick();
        check("t6_idle_after", bus.busy, 0);
        bus.req = 3'b100;
        tick();
        check("t6_restart", bus.tx_start, 1);
        check("t6_sel", bus.tx_sel, 2);
        check("t6_gnt2", bus.gnt, 3'b100);
        check("t6_len", bus.tx_len, 200);
        bus.req = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
